// File: rtl/relu_bwd_seq.sv
`default_nettype none
// ============================================================================
// relu_bwd_seq : ReLU gradient gate; forward-sample sign masks held in a FIFO
// Rev 1.0
// ============================================================================
module relu_bwd_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_fwd_valid,
  input  logic [DATA_WIDTH-1:0]   i_fwd_data,
  output logic                    o_fwd_ready,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_data_bus,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data_bus,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_overflow,
  output logic                    o_underflow
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_full = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_one  = (ADDR_WIDTH+1)'(1);

  logic                  r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_mask;

  // Strictly positive samples only; zero takes the zero-derivative branch.
  assign w_mask  = ~i_fwd_data[DATA_WIDTH-1] & (|i_fwd_data);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_full);
  assign w_ready = ~w_full | (i_valid & ~w_empty);
  assign w_push  = i_en & i_fwd_valid & w_ready;
  assign w_pop   = i_en & i_valid & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (i_en) begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
      // Read-before-write: a full push+pop sees the old entry at rd_ptr.
      r_valid <= w_pop;
      if (w_pop) begin
        r_data <= r_mem[r_rd_ptr] ? i_data_bus : '0;
      end
      if (i_fwd_valid & ~w_ready) begin
        r_overflow <= 1'b1;
      end
      if (i_valid & w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_fwd_ready = w_ready;
  assign o_valid     = r_valid;
  assign o_data_bus  = r_data;
  assign o_count     = r_count;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_relu_bwd_seq.sv
`default_nettype none
// ============================================================================
// tb_relu_bwd_seq : self-checking bench, queue-based reference model
// Rev 1.0
// ============================================================================
module tb_relu_bwd_seq;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          fv;
  logic [DW-1:0] fd;
  logic          fr;
  logic          gv;
  logic [DW-1:0] gd;
  logic          ov;
  logic [DW-1:0] od;
  logic [AW:0]   cnt;
  logic          ovf;
  logic          unf;

  relu_bwd_seq #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en),
    .i_fwd_valid(fv), .i_fwd_data(fd), .o_fwd_ready(fr),
    .i_valid(gv), .i_data_bus(gd),
    .o_valid(ov), .o_data_bus(od), .o_count(cnt),
    .o_overflow(ovf), .o_underflow(unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of "sample was > 0" bits.
  bit            m_q[$];
  bit            m_valid;
  logic [DW-1:0] m_data;
  bit            m_ovf;
  bit            m_unf;
  bit            m_ready;
  bit            m_bit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else if (en) begin
      m_ready = (m_q.size() != DEPTH) || (gv && m_q.size() != 0);
      if (gv && m_q.size() != 0) begin
        m_bit   = m_q.pop_front();
        m_valid = 1'b1;
        m_data  = m_bit ? gd : '0;
      end else begin
        m_valid = 1'b0;
        if (gv) m_unf = 1'b1;
      end
      if (fv && m_ready) m_q.push_back($signed(fd) > 0);
      if (fv && !m_ready) m_ovf = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("count",     32'(cnt), 32'(m_q.size()));
    check("fwd_ready", 32'(fr),  32'((m_q.size() != DEPTH) || (gv && m_q.size() != 0)));
    check("o_valid",   32'(ov),  32'(m_valid));
    check("o_data",    32'(od),  32'(m_data));
    check("overflow",  32'(ovf), 32'(m_ovf));
    check("underflow", 32'(unf), 32'(m_unf));
  end

  task automatic drive(input bit e, input bit f_v, input logic [DW-1:0] f_d,
                       input bit g_v, input logic [DW-1:0] g_d);
    @(posedge clk);
    #2;
    en = e; fv = f_v; fd = f_d; gv = g_v; gd = g_d;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b1; fv = 1'b0; fd = '0; gv = 1'b0; gd = '0;
    #1;
    check("rst_valid", 32'(ov),  32'h0);
    check("rst_data",  32'(od),  32'h00);
    check("rst_count", 32'(cnt), 32'h0);
    check("rst_ovf",   32'(ovf), 32'h0);
    check("rst_unf",   32'(unf), 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; fv = 1'b0; fd = '0; gv = 1'b0; gd = '0;
    #1 rst_n = 1'b0;
    #20 rst_n = 1'b1;

    // Gating
    do_reset();
    drive(1, 1, 8'h80, 0, 0);
    drive(1, 1, 8'h00, 0, 0);
    drive(1, 1, 8'h01, 0, 0);
    drive(1, 1, 8'h7F, 0, 0);
    drive(1, 0, 0, 1, 8'h11);
    drive(1, 0, 0, 1, 8'h22);
    check("gate_80", 32'(od), 32'h00);
    check("gate_v1", 32'(ov), 32'h1);
    drive(1, 0, 0, 1, 8'h33);
    check("gate_00", 32'(od), 32'h00);
    drive(1, 0, 0, 1, 8'h44);
    check("gate_01", 32'(od), 32'h33);
    idle();
    check("gate_7f", 32'(od), 32'h44);
    check("gate_v4", 32'(ov), 32'h1);
    idle();
    check("gate_v_off", 32'(ov), 32'h0);

    // Full / wrap, three rounds
    do_reset();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 20; i++) drive(1, 1, 8'(1 + $urandom_range(0, 126)), 0, 0);
      idle();
      check("full_count", 32'(cnt), 32'd16);
      check("full_ready", 32'(fr),  32'h0);
      check("full_ovf",   32'(ovf), 32'h1);
      for (int i = 0; i < 16; i++) drive(1, 0, 0, 1, 8'($urandom));
      idle();
      check("drain_count", 32'(cnt), 32'd0);
    end

    // Simultaneous push+pop at full and at empty
    do_reset();
    for (int i = 0; i < 16; i++) drive(1, 1, 8'(8'h10 + i), 0, 0);
    drive(1, 1, 8'hFF, 1, 8'h77);
    idle();
    check("sim_full_count", 32'(cnt), 32'd16);
    check("sim_full_ovf",   32'(ovf), 32'h0);
    check("sim_full_data",  32'(od),  32'h77);
    for (int i = 0; i < 16; i++) drive(1, 0, 0, 1, 8'($urandom));
    idle();
    drive(1, 1, 8'h01, 1, 8'h99);
    idle();
    check("sim_empty_unf",   32'(unf), 32'h1);
    check("sim_empty_count", 32'(cnt), 32'd1);
    check("sim_empty_valid", 32'(ov),  32'h0);

    // Underflow holds data
    do_reset();
    drive(1, 1, 8'h7F, 0, 0);
    drive(1, 0, 0, 1, 8'h3C);
    drive(1, 0, 0, 1, 8'h5A);
    check("unf_pre_data", 32'(od), 32'h3C);
    idle();
    check("unf_valid", 32'(ov),  32'h0);
    check("unf_flag",  32'(unf), 32'h1);
    check("unf_data",  32'(od),  32'h3C);

    // Enable freeze
    do_reset();
    drive(1, 1, 8'h05, 0, 0);
    drive(1, 1, 8'hF0, 0, 0);
    drive(1, 1, 8'h06, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'h01, 1, 8'hAA);
    drive(1, 0, 0, 1, 8'h11);
    check("en_count", 32'(cnt), 32'd3);
    check("en_valid", 32'(ov),  32'h0);
    check("en_unf",   32'(unf), 32'h0);
    drive(1, 0, 0, 1, 8'h22);
    check("en_ord0", 32'(od), 32'h11);
    drive(1, 0, 0, 1, 8'h33);
    check("en_ord1", 32'(od), 32'h00);
    idle();
    check("en_ord2", 32'(od), 32'h33);

    // Randomized traffic with alternating fill/drain bias
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 400; i++) begin
        drive(($urandom % 10) != 0,
              ($urandom % 100) < ((blk % 2) ? 75 : 30), 8'($urandom),
              ($urandom % 100) < ((blk % 2) ? 30 : 75), 8'($urandom));
      end
      do_reset();
    end

    idle();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
